// File: rtl/tcpc_regs_pkg.sv
// rtl/tcpc_regs_pkg.sv - register map, reset values and FSM encoding for the TCPC register bank
package tcpc_regs_pkg;

    localparam logic [7:0] ADDR_VENDOR_ID  = 8'h00;
    localparam logic [7:0] ADDR_PRODUCT_ID = 8'h02;
    localparam logic [7:0] ADDR_ALERT      = 8'h10;
    localparam logic [7:0] ADDR_ALERT_MASK = 8'h12;
    localparam logic [7:0] ADDR_CC_CONTROL = 8'h1A;
    localparam logic [7:0] ADDR_CC_STATUS  = 8'h1D;
    localparam logic [7:0] ADDR_COMMAND    = 8'h23;
    localparam logic [7:0] ADDR_RX_DETECT  = 8'h2F;

    localparam logic [7:0] CC_CONTROL_RST = 8'h0F;
    localparam logic [7:0] RX_DETECT_RST  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACKING = 2'd2
    } tcpc_state_e;

endpackage

// File: rtl/tcpc_alert_reg.sv
// rtl/tcpc_alert_reg.sv - W1C ALERT register with hardware set, ALERT_MASK and registered ALERT_N
module tcpc_alert_reg #(
    parameter logic [15:0] MASK_RST = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] alert_set,
    input  logic        alert_we,
    input  logic        mask_we,
    input  logic [15:0] wdata,
    output logic [15:0] alert,
    output logic [15:0] alert_mask,
    output logic        alert_n
);

    logic [15:0] alert_q, alert_d;
    logic [15:0] mask_q, mask_d;
    logic        alert_n_q, alert_n_d;
    logic [15:0] clr;

    // Set is OR-ed after the clear so a coincident set pulse survives the W1C.
    always_comb begin
        clr       = alert_we ? wdata : 16'h0000;
        alert_d   = (alert_q & ~clr) | alert_set;
        mask_d    = mask_we ? wdata : mask_q;
        alert_n_d = ~|(alert_d & mask_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alert_q   <= 16'h0000;
            mask_q    <= MASK_RST;
            alert_n_q <= 1'b1;
        end else begin
            alert_q   <= alert_d;
            mask_q    <= mask_d;
            alert_n_q <= alert_n_d;
        end
    end

    assign alert      = alert_q;
    assign alert_mask = mask_q;
    assign alert_n    = alert_n_q;

endmodule

// File: rtl/tcpc_reg_bank.sv
// rtl/tcpc_reg_bank.sv - TCPC control/status register file behind the register-access arbiter
module tcpc_reg_bank
    import tcpc_regs_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID      = 16'h1234,
    parameter logic [15:0] PRODUCT_ID     = 16'h5678,
    parameter logic [15:0] ALERT_MASK_RST = 16'h7FFF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQUEST,
    input  logic        RWN,
    input  logic [7:0]  ADDR,
    input  logic [15:0] WR_DATA,
    output logic [15:0] RD_DATA,
    output logic        ACK,
    input  logic [15:0] ALERT_SET,
    input  logic [7:0]  CC_STATUS_IN,
    output logic        ALERT_N,
    output logic [7:0]  CC_CONTROL,
    output logic [7:0]  RX_DETECT,
    output logic        CMD_STROBE,
    output logic [7:0]  CMD_CODE
);

    tcpc_state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        rwn_q, rwn_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        ack_q, ack_d;
    logic [7:0]  cc_control_q, cc_control_d;
    logic [7:0]  rx_detect_q, rx_detect_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [7:0]  cmd_code_q, cmd_code_d;

    logic        alert_we, mask_we;
    logic [15:0] alert, alert_mask;
    logic [15:0] rd_mux;

    tcpc_alert_reg #(.MASK_RST(ALERT_MASK_RST)) u_alert (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .alert_set  (ALERT_SET),
        .alert_we   (alert_we),
        .mask_we    (mask_we),
        .wdata      (wdata_q),
        .alert      (alert),
        .alert_mask (alert_mask),
        .alert_n    (ALERT_N)
    );

    // ALERT is read from the register, so a set pulse in the same cycle is not visible yet.
    always_comb begin
        rd_mux = 16'h0000;
        case (addr_q)
            ADDR_VENDOR_ID:  rd_mux = VENDOR_ID;
            ADDR_PRODUCT_ID: rd_mux = PRODUCT_ID;
            ADDR_ALERT:      rd_mux = alert;
            ADDR_ALERT_MASK: rd_mux = alert_mask;
            ADDR_CC_CONTROL: rd_mux = {8'h00, cc_control_q};
            ADDR_CC_STATUS:  rd_mux = {8'h00, CC_STATUS_IN};
            ADDR_RX_DETECT:  rd_mux = {8'h00, rx_detect_q};
            default:         rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rwn_d        = rwn_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        ack_d        = ack_q;
        cc_control_d = cc_control_q;
        rx_detect_d  = rx_detect_q;
        cmd_code_d   = cmd_code_q;
        cmd_strobe_d = 1'b0;
        alert_we     = 1'b0;
        mask_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQUEST) begin
                    addr_d  = ADDR;
                    rwn_d   = RWN;
                    wdata_d = WR_DATA;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ack_d   = 1'b1;
                state_d = ST_ACKING;
                if (rwn_q) begin
                    rd_data_d = rd_mux;
                end else begin
                    case (addr_q)
                        ADDR_ALERT:      alert_we = 1'b1;
                        ADDR_ALERT_MASK: mask_we = 1'b1;
                        ADDR_CC_CONTROL: cc_control_d = wdata_q[7:0];
                        ADDR_RX_DETECT:  rx_detect_d = wdata_q[7:0];
                        ADDR_COMMAND: begin
                            cmd_code_d   = wdata_q[7:0];
                            cmd_strobe_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ACKING: begin
                if (!REQUEST) begin
                    ack_d     = 1'b0;
                    rd_data_d = 16'h0000;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            addr_q       <= 8'h00;
            rwn_q        <= 1'b1;
            wdata_q      <= 16'h0000;
            rd_data_q    <= 16'h0000;
            ack_q        <= 1'b0;
            cc_control_q <= CC_CONTROL_RST;
            rx_detect_q  <= RX_DETECT_RST;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rwn_q        <= rwn_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            ack_q        <= ack_d;
            cc_control_q <= cc_control_d;
            rx_detect_q  <= rx_detect_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
        end
    end

    assign RD_DATA    = rd_data_q;
    assign ACK        = ack_q;
    assign CC_CONTROL = cc_control_q;
    assign RX_DETECT  = rx_detect_q;
    assign CMD_STROBE = cmd_strobe_q;
    assign CMD_CODE   = cmd_code_q;

endmodule

// File: tb/tb_tcpc_reg_bank.sv
// tb/tb_tcpc_reg_bank.sv - randomized self-checking bench for tcpc_reg_bank against a register-map model
module tb_tcpc_reg_bank;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQUEST = 1'b0;
    logic        RWN = 1'b1;
    logic [7:0]  ADDR = 8'h00;
    logic [15:0] WR_DATA = 16'h0000;
    logic [15:0] ALERT_SET = 16'h0000;
    logic [7:0]  CC_STATUS_IN = 8'h00;
    logic [15:0] RD_DATA;
    logic        ACK;
    logic        ALERT_N;
    logic [7:0]  CC_CONTROL;
    logic [7:0]  RX_DETECT;
    logic        CMD_STROBE;
    logic [7:0]  CMD_CODE;

    tcpc_reg_bank dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .REQUEST      (REQUEST),
        .RWN          (RWN),
        .ADDR         (ADDR),
        .WR_DATA      (WR_DATA),
        .RD_DATA      (RD_DATA),
        .ACK          (ACK),
        .ALERT_SET    (ALERT_SET),
        .CC_STATUS_IN (CC_STATUS_IN),
        .ALERT_N      (ALERT_N),
        .CC_CONTROL   (CC_CONTROL),
        .RX_DETECT    (RX_DETECT),
        .CMD_STROBE   (CMD_STROBE),
        .CMD_CODE     (CMD_CODE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural register map
    logic [15:0] m_alert, m_mask;
    logic [7:0]  m_cc, m_rx, m_code;

    task automatic m_reset();
        m_alert = 16'h0000;
        m_mask  = 16'h7FFF;
        m_cc    = 8'h0F;
        m_rx    = 8'h00;
        m_code  = 8'h00;
    endtask

    function automatic logic [15:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h1234;
            8'h02:   return 16'h5678;
            8'h10:   return m_alert;
            8'h12:   return m_mask;
            8'h1A:   return {8'h00, m_cc};
            8'h1D:   return {8'h00, CC_STATUS_IN};
            8'h2F:   return {8'h00, m_rx};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [15:0] d);
        case (a)
            8'h10: m_alert = m_alert & ~d;
            8'h12: m_mask = d;
            8'h1A: m_cc = d[7:0];
            8'h23: m_code = d[7:0];
            8'h2F: m_rx = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic m_alert_n();
        return ~|(m_alert & m_mask);
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_cc"}, CC_CONTROL, m_cc);
        chk({tag, "_rx"}, RX_DETECT, m_rx);
        chk({tag, "_code"}, CMD_CODE, m_code);
        chk({tag, "_alert_n"}, ALERT_N, m_alert_n());
    endtask

    // Full four-phase access; set_pulse is driven during the DECODE cycle.
    task automatic access(input logic rwn, input logic [7:0] a, input logic [15:0] wd,
                          input logic [15:0] set_pulse, input int hold, output logic [15:0] rd);
        int strobes;
        logic [15:0] exp_rd;
        strobes = 0;
        @(negedge CLK);
        REQUEST = 1'b1; RWN = rwn; ADDR = a; WR_DATA = wd;
        @(negedge CLK);
        chk("ack_early", ACK, 1'b0);
        strobes += int'(CMD_STROBE);
        ADDR = 8'($urandom); WR_DATA = 16'($urandom); RWN = ~rwn;
        ALERT_SET = set_pulse;
        exp_rd = rwn ? m_read(a) : 16'h0000;
        if (!rwn) m_write(a, wd);
        m_alert = m_alert | set_pulse;
        @(negedge CLK);
        ALERT_SET = 16'h0000;
        strobes += int'(CMD_STROBE);
        chk("ack_rise", ACK, 1'b1);
        if (rwn) chk("rd_data", RD_DATA, exp_rd);
        rd = RD_DATA;
        chk("alert_n_commit", ALERT_N, m_alert_n());
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            strobes += int'(CMD_STROBE);
            chk("ack_hold", ACK, 1'b1);
            chk("rd_hold", RD_DATA, rd);
        end
        REQUEST = 1'b0;
        @(negedge CLK);
        strobes += int'(CMD_STROBE);
        chk("ack_fall", ACK, 1'b0);
        chk("rd_clear", RD_DATA, 16'h0000);
        chk("strobe_count", strobes, (!rwn && a == 8'h23) ? 1 : 0);
        check_regs("post");
    endtask

    task automatic pulse_set(input logic [15:0] v);
        @(negedge CLK);
        ALERT_SET = v;
        m_alert = m_alert | v;
        @(negedge CLK);
        ALERT_SET = 16'h0000;
        chk("alert_n_set", ALERT_N, m_alert_n());
    endtask

    logic [15:0] rd;
    logic [7:0]  map_addrs [8] = '{8'h00, 8'h02, 8'h10, 8'h12, 8'h1A, 8'h1D, 8'h23, 8'h2F};

    initial begin
        m_reset();
        repeat (2) @(negedge CLK);
        chk("rst_ack", ACK, 1'b0);
        chk("rst_rd", RD_DATA, 16'h0000);
        chk("rst_strobe", CMD_STROBE, 1'b0);
        check_regs("rst");
        RESET_N = 1'b1;

        access(1'b1, 8'h00, 16'h0, 16'h0, 0, rd);
        chk("vendor_id", rd, 16'h1234);
        access(1'b1, 8'h12, 16'h0, 16'h0, 1, rd);
        chk("mask_rst", rd, 16'h7FFF);

        access(1'b0, 8'h1A, 16'hABCD, 16'h0, 0, rd);
        access(1'b1, 8'h1A, 16'h0, 16'h0, 0, rd);
        chk("cc_readback", rd, 16'h00CD);
        chk("cc_out", CC_CONTROL, 8'hCD);
        access(1'b0, 8'h00, 16'hFFFF, 16'h0, 0, rd);
        access(1'b1, 8'h00, 16'h0, 16'h0, 0, rd);
        chk("ro_ignored", rd, 16'h1234);

        pulse_set(16'h0005);
        chk("alert_n_low", ALERT_N, 1'b0);
        access(1'b0, 8'h10, 16'h0001, 16'h0, 0, rd);
        access(1'b1, 8'h10, 16'h0, 16'h0, 0, rd);
        chk("w1c_partial", rd, 16'h0004);
        access(1'b0, 8'h10, 16'h0004, 16'h0, 0, rd);
        chk("alert_n_clear", ALERT_N, 1'b1);

        pulse_set(16'h0004);
        access(1'b0, 8'h10, 16'h0004, 16'h0004, 0, rd);
        chk("set_wins_n", ALERT_N, 1'b0);
        access(1'b1, 8'h10, 16'h0, 16'h0, 0, rd);
        chk("set_wins", rd, 16'h0004);
        access(1'b0, 8'h12, 16'h0000, 16'h0, 0, rd);
        chk("masked_n", ALERT_N, 1'b1);

        access(1'b0, 8'h23, 16'h00AA, 16'h0, 0, rd);
        chk("cmd_code", CMD_CODE, 8'hAA);
        access(1'b1, 8'h23, 16'h0, 16'h0, 0, rd);
        chk("cmd_reads0", rd, 16'h0000);
        access(1'b1, 8'h55, 16'h0, 16'h0, 0, rd);
        chk("unmapped", rd, 16'h0000);

        // REQUEST dropped while in DECODE: access completes with a one-cycle ACK
        @(negedge CLK);
        REQUEST = 1'b1; RWN = 1'b0; ADDR = 8'h2F; WR_DATA = 16'h3C5A;
        @(negedge CLK);
        REQUEST = 1'b0;
        m_write(8'h2F, 16'h3C5A);
        @(negedge CLK);
        chk("short_ack", ACK, 1'b1);
        @(negedge CLK);
        chk("short_ack_drop", ACK, 1'b0);
        chk("short_rx", RX_DETECT, 8'h5A);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            logic [15:0] sp;
            CC_STATUS_IN = 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : map_addrs[$urandom_range(0, 7)];
            sp = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
            if ($urandom_range(0, 3) == 0) pulse_set(16'(1 << $urandom_range(0, 15)));
            access(1'($urandom), a, 16'($urandom), sp, $urandom_range(0, 2), rd);
        end

        // Reset while ACKING: everything returns to reset values immediately
        access(1'b0, 8'h12, 16'hFFFF, 16'h0, 0, rd);
        access(1'b0, 8'h1A, 16'h0033, 16'h0, 0, rd);
        pulse_set(16'h0001);
        chk("pre_rst_alert_n", ALERT_N, 1'b0);
        @(negedge CLK);
        REQUEST = 1'b1; RWN = 1'b1; ADDR = 8'h00;
        repeat (2) @(negedge CLK);
        chk("pre_rst_ack", ACK, 1'b1);
        RESET_N = 1'b0;
        #1;
        m_reset();
        chk("async_ack", ACK, 1'b0);
        chk("async_rd", RD_DATA, 16'h0000);
        check_regs("async");
        REQUEST = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;

        // Reset while in DECODE: the pending write never commits
        @(negedge CLK);
        REQUEST = 1'b1; RWN = 1'b0; ADDR = 8'h1A; WR_DATA = 16'h0055;
        @(negedge CLK);
        RESET_N = 1'b0;
        REQUEST = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("decode_rst_ack", ACK, 1'b0);
        check_regs("decode_rst");
        access(1'b1, 8'h1A, 16'h0, 16'h0, 0, rd);
        chk("decode_rst_cc", rd, 16'h000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
